// File: rtl/span_pkg.sv
// Shared types and constants for the SPAN scanning-risk front end.
package span_pkg;

  localparam int unsigned NUM_SCEN_DEF = 16;
  localparam int unsigned LOSS_W       = 16;

  typedef logic signed [LOSS_W-1:0] loss_t;
  typedef logic        [LOSS_W-1:0] rate_t;

  typedef enum logic [1:0] {
    SCAN0,
    SCAN1,
    HOLD
  } scan_state_t;

  // Signed maximum of the running value and a new scenario loss.
  function automatic loss_t loss_max(input loss_t cur, input loss_t cand);
    return (cand > cur) ? cand : cur;
  endfunction

endpackage

// File: rtl/scan_max_acc.sv
// Signed running-max register; restart returns it to zero so the result is clamped at 0.
module scan_max_acc
  import span_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  restart,
  input  logic  en,
  input  loss_t loss,
  output loss_t max
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max <= '0;
    end else if (restart) begin
      max <= '0;
    end else if (en) begin
      max <= loss_max(max, loss);
    end
  end

endmodule

// File: rtl/scan_risk_max.sv
// Scanning risk per commodity for a two-commodity SPAN pair, published as an
// atomic outrightRate pair one cycle after the final scenario of the frame.
module scan_risk_max
  import span_pkg::*;
#(
  parameter int unsigned NUM_SCEN = NUM_SCEN_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  scen_valid,
  output logic  scen_ready,
  input  loss_t scen_loss,
  input  logic  scen_comm,
  input  logic  scen_last,
  input  logic  clear_err,
  output rate_t outrightRate [0:1],
  output logic  rate_valid,
  output logic  frame_err
);

  localparam int unsigned CNT_W = (NUM_SCEN > 1) ? $clog2(NUM_SCEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SCEN - 1);

  scan_state_t      r_state;
  scan_state_t      w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             r_ready;
  loss_t            r_shadow;
  loss_t            w_acc_max;
  loss_t            w_fold;
  logic             w_xfer;
  logic             w_cnt_last;
  logic             w_err;

  assign w_xfer     = scen_valid & r_ready;
  assign w_cnt_last = (r_cnt == LAST_IDX);
  // Final value of the current commodity including the sample on this edge.
  assign w_fold     = loss_max(w_acc_max, scen_loss);
  assign w_err      = (scen_last != w_cnt_last) || (scen_comm != (r_state == SCAN1));
  assign scen_ready = r_ready;

  scan_max_acc u_acc (
    .clk     (clk),
    .reset   (reset),
    .restart (w_xfer & w_cnt_last),
    .en      (w_xfer),
    .loss    (scen_loss),
    .max     (w_acc_max)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      SCAN0, SCAN1: begin
        if (w_xfer) begin
          w_next_cnt = w_cnt_last ? '0 : r_cnt + CNT_W'(1);
          if (w_cnt_last) begin
            w_next_state = (r_state == SCAN0) ? SCAN1 : HOLD;
          end
        end
      end
      HOLD:    w_next_state = SCAN0;
      default: w_next_state = SCAN0;
    endcase
  end

  // scen_ready is registered alongside the state so it is low exactly in HOLD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SCAN0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_ready <= (w_next_state != HOLD);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow        <= '0;
      outrightRate[0] <= '0;
      outrightRate[1] <= '0;
      rate_valid      <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (w_xfer && w_cnt_last) begin
        if (r_state == SCAN0) begin
          r_shadow <= w_fold;
        end else begin
          outrightRate[0] <= rate_t'(r_shadow);
          outrightRate[1] <= rate_t'(w_fold);
          rate_valid      <= 1'b1;
        end
      end
      // A new framing error takes priority over a same-cycle clear.
      if (w_xfer && w_err) begin
        frame_err <= 1'b1;
      end else if (clear_err) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/scan_risk_max.md
Name: scan_risk_max

Overview:
- Upstream feeder for the cross-commodity charge stage.
- Consumes a stream of SPAN risk-array scenario losses for a two-commodity pair, commodity 0 first, then commodity 1.
- For each commodity it finds the worst-case loss (the scanning risk), clamped at zero.
- Presents both results together as the outrightRate pair that the downstream charge stage multiplies by the ratios and the inter-commodity rate.

Parameters:
- NUM_SCEN, 16: scenarios per commodity in one risk array.
- LOSS_W, 16: width of the signed scenario loss and of each unsigned outrightRate output.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- scen_valid  in  1  scenario loss presented.
- scen_ready  out  1  block accepts a scenario this cycle.
- scen_loss  in  LOSS_W  signed two's-complement scenario loss; negative means gain.
- scen_comm  in  1  commodity tag of the presented scenario.
- scen_last  in  1  marks the final scenario of a commodity.
- clear_err  in  1  synchronous clear of frame_err.
- outrightRate  out  LOSS_W x [0:1]  scanning risk per commodity.
- rate_valid  out  1  one-cycle pulse when outrightRate updates.
- frame_err  out  1  sticky framing error.

Behaviour:
- Transfer occurs only when scen_valid=1 and scen_ready=1 on a rising clk edge.
- Reset is asynchronous. While reset=0:
  - state=SCAN0, scenario counter=0, running max=0.
  - outrightRate[0]=outrightRate[1]=0, rate_valid=0, frame_err=0.
  - Reset asserted mid-frame discards the partial frame; the next frame starts at SCAN0.
- States:
  - SCAN0: accumulate commodity 0; scen_ready=1.
  - SCAN1: accumulate commodity 1; scen_ready=1.
  - HOLD: single cycle; scen_ready=0.
- Transitions:
  - SCAN0 -> SCAN1 on the NUM_SCEN-th transfer.
  - SCAN1 -> HOLD on the NUM_SCEN-th transfer.
  - HOLD -> SCAN0 unconditionally on the next clock edge.
- Running max:
  - Cleared to 0 at the start of each commodity.
  - On each transfer, max <= scen_loss if scen_loss > max, using a signed compare. Negative losses therefore never raise it; the result is implicitly clamped at 0.
- Commodity 0 handoff: the commodity 0 max is held in an internal shadow register. outrightRate[0] does not change until the frame completes.
- Frame completion:
  - On the final commodity 1 transfer (edge N), the next registered state is HOLD.
  - During that HOLD cycle, outrightRate[0]=shadow, outrightRate[1]=final max, rate_valid=1.
  - Latency: rate_valid is high in the cycle immediately after the last transfer.
  - rate_valid is low in all other cycles.
- outrightRate holds its value between updates. Any downstream sample taken at any time sees a consistent pair.
- Scenario count is governed by the counter. The counter wraps to 0 at each commodity boundary.
- frame_err is sticky and is set on any transfer where:
  - scen_last differs from (counter==NUM_SCEN-1), or
  - scen_comm differs from the current state's commodity.
- An erroneous sample is still accumulated into the current commodity. Framing continues by count.
- clear_err=1 clears frame_err on the next edge. A simultaneous new error wins, so frame_err stays 1.
- scen_valid held during HOLD is not consumed. The producer must keep data stable until the transfer occurs.
- Result width: max fits in LOSS_W-1 bits (0..2^(LOSS_W-1)-1) and is zero-extended to LOSS_W. No saturation is needed.

Decomposition:
- Shared package span_pkg holds:
  - NUM_SCEN default constant.
  - loss_t, signed [LOSS_W-1:0].
  - rate_t, unsigned [LOSS_W-1:0].
  - scan_state_t enum {SCAN0, SCAN1, HOLD}.
- One sub-module, scan_max_acc:
  - Signed running-max register with synchronous restart.
  - Inputs: clk, reset, restart, en, loss. Output: max.
  - Instantiated once and shared by both commodities.

Test Plan:
- Basic frame:
  - Stimulus: commodity 0 losses 0,10,...,150 (max 150); commodity 1 all -5; scen_valid=1 continuously.
  - Response: rate_valid high exactly in the cycle after the 32nd transfer; outrightRate={150,0}; scen_ready=0 in that cycle.
- Signed extremes:
  - Stimulus: commodity 0 contains -32768 and 32767; commodity 1 losses -1,1,2,...
  - Response: outrightRate={32767,15}; no false max from -32768.
- Back-pressure and gaps:
  - Stimulus: random scen_valid gaps; a third frame's first sample offered during HOLD.
  - Response: that sample is accepted only on the cycle after HOLD; results match the gap-free run.
- Framing error:
  - Stimulus: scen_last=1 at commodity 0 index 7.
  - Response: frame_err rises on the next edge; the frame still completes after 32 transfers; clear_err then drops frame_err.
- Reset mid-frame:
  - Stimulus: assert reset asynchronously after 20 transfers.
  - Response: outrightRate=0 and rate_valid=0 immediately; a following clean frame with maxima 40 and 90 yields {40,90}.
- Back-to-back frames:
  - Stimulus: frame A {100,200} then frame B {7,3}.
  - Response: outputs hold {100,200} until B's rate_valid pulse, then show {7,3}.
